multicycle_core: RTL and testbench

// - Parametrised multi-cycle successor to the single-cycle push-button datapath: FSM-sequenced fetch/decode/exec/mem/wb.
// - Generic data width and register count; mode-selectable free-run or single-step, so the core needs no gated/debounced clock.
// - Data memory reached through a req/ready handshake (wait states allowed).
// - Sits under the board top; the top provides the instruction ROM, data RAM, debouncer and 7-seg/VIO debug.

---
 rtl/core_pkg.sv | 53 +++++
 rtl/core_regfile.sv | 41 ++++
 rtl/multicycle_core.sv | 175 +++++++++++++++++
 tb/tb_multicycle_core.sv | 359 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/core_pkg.sv
// Shared definitions for the multi-cycle core: opcodes, FSM states,
// instruction field positions and the immediate sign-extension helper.
package core_pkg;

  typedef enum logic [3:0] {
    OP_ADD  = 4'h0,
    OP_SUB  = 4'h1,
    OP_AND  = 4'h2,
    OP_OR   = 4'h3,
    OP_XOR  = 4'h4,
    OP_SLT  = 4'h5,
    OP_ADDI = 4'h6,
    OP_LW   = 4'h8,
    OP_SW   = 4'h9,
    OP_BEQ  = 4'hA,
    OP_BNE  = 4'hB,
    OP_HALT = 4'hF
  } opcode_t;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_HALT   = 3'd6
  } state_t;

  localparam int OP_MSB  = 15;
  localparam int OP_LSB  = 12;
  localparam int RD_MSB  = 11;
  localparam int RD_LSB  = 9;
  localparam int RS1_MSB = 8;
  localparam int RS1_LSB = 6;
  localparam int RS2_MSB = 5;
  localparam int RS2_LSB = 3;
  localparam int IMM_MSB = 5;
  localparam int IMM_LSB = 0;

  // Widest supported XLEN is 32; callers truncate with a size cast.
  function automatic logic signed [31:0] sext6(input logic [5:0] f);
    return {{26{f[5]}}, f};
  endfunction

  function automatic logic writes_rd(input logic [3:0] op);
    case (op)
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_SLT, OP_ADDI, OP_LW: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/core_regfile.sv
// Register file: two asynchronous read ports, one synchronous write port,
// r0 hardwired to zero, synchronous active-low clear of every register.
module core_regfile
  import core_pkg::*;
#(
  parameter int XLEN = 16,
  parameter int NREG = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            we,
  input  logic [2:0]      waddr,
  input  logic [XLEN-1:0] wdata,
  input  logic [2:0]      raddr_a,
  input  logic [2:0]      raddr_b,
  output logic [XLEN-1:0] rdata_a,
  output logic [XLEN-1:0] rdata_b
);

  localparam int AW = (NREG > 1) ? $clog2(NREG) : 1;

  logic [XLEN-1:0] regs_q [NREG];
  logic [AW-1:0]   wa, ra, rb;

  // Upper index bits are dropped on purpose so small files alias.
  assign wa = waddr[AW-1:0];
  assign ra = raddr_a[AW-1:0];
  assign rb = raddr_b[AW-1:0];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) regs_q[i] <= '0;
    end else if (we && (wa != '0)) begin
      regs_q[wa] <= wdata;
    end
  end

  assign rdata_a = (ra == '0) ? '0 : regs_q[ra];
  assign rdata_b = (rb == '0) ? '0 : regs_q[rb];

endmodule

// File: rtl/multicycle_core.sv
// Multi-cycle core: FSM-sequenced fetch/decode/exec/mem/wb with free-run or
// single-step operation and a req/ready data-memory port.
module multicycle_core
  import core_pkg::*;
#(
  parameter int XLEN = 16,
  parameter int NREG = 8,
  parameter int PC_W = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            run,
  input  logic            step,
  output logic [PC_W-1:0] imem_addr,
  input  logic [15:0]     imem_data,
  output logic            dmem_req,
  output logic            dmem_we,
  output logic [XLEN-1:0] dmem_addr,
  output logic [XLEN-1:0] dmem_wdata,
  input  logic [XLEN-1:0] dmem_rdata,
  input  logic            dmem_ready,
  output logic            retire,
  output logic            halted,
  output logic            ovf,
  output logic [PC_W-1:0] dbg_pc,
  output logic [XLEN-1:0] dbg_wb_data
);

  state_t          state_q, state_d;
  logic            step_q;
  logic [PC_W-1:0] pc_q;
  logic [15:0]     ir_q;
  logic [XLEN-1:0] a_q, b_q, res_q, wb_q;
  logic            taken_q, ovf_q;

  logic [3:0]      op;
  logic [2:0]      f_rd, f_rs1, f_rs2;
  logic            is_branch;
  logic [2:0]      ra_a, ra_b;
  logic [XLEN-1:0] rdata_a, rdata_b;
  logic [XLEN-1:0] imm;
  logic [PC_W-1:0] off;
  logic [XLEN-1:0] sum, diff, addi;
  logic [XLEN-1:0] alu_res;
  logic            alu_ovf, br_taken, rf_we;

  assign op    = ir_q[OP_MSB:OP_LSB];
  assign f_rd  = ir_q[RD_MSB:RD_LSB];
  assign f_rs1 = ir_q[RS1_MSB:RS1_LSB];
  assign f_rs2 = ir_q[RS2_MSB:RS2_LSB];
  assign imm   = XLEN'(sext6(ir_q[IMM_MSB:IMM_LSB]));
  assign off   = PC_W'(sext6(ir_q[IMM_MSB:IMM_LSB]));

  // Branches and stores move their source registers into the rd slot.
  assign is_branch = (op == OP_BEQ) || (op == OP_BNE);
  assign ra_a = is_branch ? f_rd : f_rs1;
  assign ra_b = (op == OP_SW) ? f_rd : (is_branch ? f_rs1 : f_rs2);

  assign rf_we = (state_q == S_WB) && writes_rd(op);

  core_regfile #(.XLEN(XLEN), .NREG(NREG)) u_regfile (
    .clk     (clk),
    .rst_n   (rst_n),
    .we      (rf_we),
    .waddr   (f_rd),
    .wdata   (res_q),
    .raddr_a (ra_a),
    .raddr_b (ra_b),
    .rdata_a (rdata_a),
    .rdata_b (rdata_b)
  );

  assign sum  = a_q + b_q;
  assign diff = a_q - b_q;
  assign addi = a_q + imm;

  always_comb begin
    alu_res = '0;
    alu_ovf = 1'b0;
    case (op)
      OP_ADD: begin
        alu_res = sum;
        alu_ovf = (a_q[XLEN-1] == b_q[XLEN-1]) && (sum[XLEN-1] != a_q[XLEN-1]);
      end
      OP_SUB: begin
        alu_res = diff;
        alu_ovf = (a_q[XLEN-1] != b_q[XLEN-1]) && (diff[XLEN-1] != a_q[XLEN-1]);
      end
      OP_AND: alu_res = a_q & b_q;
      OP_OR:  alu_res = a_q | b_q;
      OP_XOR: alu_res = a_q ^ b_q;
      OP_SLT: alu_res = XLEN'($signed(a_q) < $signed(b_q));
      OP_ADDI: begin
        alu_res = addi;
        alu_ovf = (a_q[XLEN-1] == imm[XLEN-1]) && (addi[XLEN-1] != a_q[XLEN-1]);
      end
      OP_LW, OP_SW: alu_res = addi;
      default: alu_res = '0;
    endcase
  end

  assign br_taken = ((op == OP_BEQ) && (a_q == b_q)) ||
                    ((op == OP_BNE) && (a_q != b_q));

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:   if (run || (step && !step_q)) state_d = S_FETCH;
      S_FETCH:  state_d = S_DECODE;
      S_DECODE: state_d = S_EXEC;
      S_EXEC: begin
        if ((op == OP_LW) || (op == OP_SW)) state_d = S_MEM;
        else if (op == OP_HALT)             state_d = S_HALT;
        else                                state_d = S_WB;
      end
      S_MEM:    if (dmem_ready) state_d = S_WB;
      S_WB:     state_d = S_IDLE;
      S_HALT:   state_d = S_HALT;
      default:  state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      step_q  <= 1'b0;
      pc_q    <= '0;
      ir_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      wb_q    <= '0;
      taken_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      // Tracks step every cycle, so an edge seen outside IDLE is lost.
      step_q  <= step;
      case (state_q)
        S_FETCH:  ir_q <= imem_data;
        S_DECODE: begin
          a_q <= rdata_a;
          b_q <= rdata_b;
        end
        S_EXEC: begin
          res_q   <= alu_res;
          taken_q <= br_taken;
          if (alu_ovf) ovf_q <= 1'b1;
        end
        S_MEM: if (dmem_ready && (op == OP_LW)) res_q <= dmem_rdata;
        S_WB: begin
          pc_q <= taken_q ? (pc_q + PC_W'(1) + off) : (pc_q + PC_W'(1));
          if (writes_rd(op)) wb_q <= res_q;
        end
        default: ;
      endcase
    end
  end

  // Data port: dmem_req is the valid; a transfer completes in the first cycle
  // where dmem_req && dmem_ready. we/addr/wdata come from registers that do
  // not change in MEM, so they are stable for the whole request.
  assign dmem_req    = (state_q == S_MEM);
  assign dmem_we     = dmem_req && (op == OP_SW);
  assign dmem_addr   = res_q;
  assign dmem_wdata  = b_q;

  assign imem_addr   = pc_q;
  assign retire      = (state_q == S_WB);
  assign halted      = (state_q == S_HALT);
  assign ovf         = ovf_q;
  assign dbg_pc      = pc_q;
  assign dbg_wb_data = wb_q;

endmodule

// File: tb/tb_multicycle_core.sv
// Directed bench for multicycle_core: instruction ROM and wait-state data RAM
// models, hand-computed expectations checked through one task.
module tb_multicycle_core;

  localparam int XLEN = 16;
  localparam int NREG = 8;
  localparam int PC_W = 8;

  logic            clk = 1'b0;
  logic            rst_n, run, step;
  logic [PC_W-1:0] imem_addr;
  logic [15:0]     imem_data;
  logic            dmem_req, dmem_we, dmem_ready;
  logic [XLEN-1:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic            retire, halted, ovf;
  logic [PC_W-1:0] dbg_pc;
  logic [XLEN-1:0] dbg_wb_data;

  multicycle_core #(.XLEN(XLEN), .NREG(NREG), .PC_W(PC_W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .run         (run),
    .step        (step),
    .imem_addr   (imem_addr),
    .imem_data   (imem_data),
    .dmem_req    (dmem_req),
    .dmem_we     (dmem_we),
    .dmem_addr   (dmem_addr),
    .dmem_wdata  (dmem_wdata),
    .dmem_rdata  (dmem_rdata),
    .dmem_ready  (dmem_ready),
    .retire      (retire),
    .halted      (halted),
    .ovf         (ovf),
    .dbg_pc      (dbg_pc),
    .dbg_wb_data (dbg_wb_data)
  );

  // clock / reset
  always #5 clk = ~clk;

  // memory models
  logic [15:0]     imem [256];
  logic [XLEN-1:0] dmem [16];
  int              dmem_delay = 0;
  int              wait_cnt = 0;

  assign imem_data  = imem[imem_addr];
  assign dmem_ready = dmem_req && (wait_cnt == dmem_delay);
  assign dmem_rdata = dmem[dmem_addr[3:0]];

  always @(posedge clk) begin
    if (!dmem_req || dmem_ready) wait_cnt <= 0;
    else                         wait_cnt <= wait_cnt + 1;
    if (dmem_req && dmem_ready && dmem_we) dmem[dmem_addr[3:0]] <= dmem_wdata;
  end

  // monitor
  int              cyc = 0, retire_cnt = 0, last_ret_cyc = 0;
  int              cur_len = 0, stab_err = 0;
  int              len_q[$];
  logic [XLEN-1:0] addr_q[$], wd_q[$];
  logic            we_q[$];
  logic [XLEN-1:0] prev_addr, prev_wd;
  logic            prev_we;

  always @(negedge clk) begin
    cyc++;
    if (retire) begin
      retire_cnt++;
      last_ret_cyc = cyc;
    end
    if (dmem_req) begin
      if (cur_len > 0 && (dmem_addr !== prev_addr || dmem_wdata !== prev_wd || dmem_we !== prev_we))
        stab_err++;
      cur_len++;
      prev_addr = dmem_addr;
      prev_wd   = dmem_wdata;
      prev_we   = dmem_we;
      if (dmem_ready) begin
        len_q.push_back(cur_len);
        addr_q.push_back(dmem_addr);
        wd_q.push_back(dmem_wdata);
        we_q.push_back(dmem_we);
        cur_len = 0;
      end
    end else begin
      cur_len = 0;
    end
  end

  // scoreboard
  int              n_cmp = 0, n_err = 0;
  logic [XLEN-1:0] exp_q[$];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // driver tasks
  function automatic logic [15:0] enc_r(input logic [3:0] op, input logic [2:0] rd,
                                        input logic [2:0] rs1, input logic [2:0] rs2);
    return {op, rd, rs1, rs2, 3'b000};
  endfunction

  function automatic logic [15:0] enc_i(input logic [3:0] op, input logic [2:0] rd,
                                        input logic [2:0] rs1, input int imm);
    logic [5:0] f;
    f = 6'(imm);
    return {op, rd, rs1, f};
  endfunction

  task automatic clear_imem();
    for (int i = 0; i < 256; i++) imem[i] = 16'h7000;
  endtask

  task automatic do_reset(input logic run_v);
    @(negedge clk);
    rst_n = 1'b0;
    run   = run_v;
    step  = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic wait_retires(input int n, input int budget, input string tag);
    int target;
    int k;
    target = retire_cnt + n;
    k = 0;
    while (retire_cnt < target && k < budget) begin
      @(negedge clk);
      #1;
      k++;
    end
    if (retire_cnt < target) check_eq(tag, retire_cnt, target);
    @(negedge clk);
    #1;
  endtask

  task automatic step_pulse();
    @(negedge clk);
    step = 1'b1;
    repeat (10) @(negedge clk);
    step = 1'b0;
    repeat (10) @(negedge clk);
  endtask

  logic [XLEN-1:0] alu_exp [9];
  int t0, t1, t2, base;

  initial begin
    rst_n = 1'b0;
    run   = 1'b0;
    step  = 1'b0;
    for (int i = 0; i < 16; i++) dmem[i] = '0;

    // free-run ALU sequence
    clear_imem();
    imem[0]  = enc_i(4'h6, 3'd1, 3'd0, 5);
    imem[1]  = enc_i(4'h6, 3'd2, 3'd0, -3);
    imem[2]  = enc_r(4'h0, 3'd3, 3'd1, 3'd2);
    imem[3]  = enc_r(4'h1, 3'd4, 3'd2, 3'd1);
    imem[4]  = enc_r(4'h2, 3'd5, 3'd1, 3'd2);
    imem[5]  = enc_r(4'h3, 3'd6, 3'd1, 3'd2);
    imem[6]  = enc_r(4'h4, 3'd7, 3'd1, 3'd2);
    imem[7]  = enc_r(4'h5, 3'd4, 3'd1, 3'd2);
    imem[8]  = enc_r(4'h5, 3'd4, 3'd2, 3'd1);
    imem[9]  = 16'h7000;
    imem[10] = 16'hF000;
    alu_exp = '{16'h0005, 16'hFFFD, 16'h0002, 16'hFFF8, 16'h0005,
                16'hFFFD, 16'hFFF8, 16'h0000, 16'h0001};
    do_reset(1'b0);
    #1;
    check_eq("rst_req", dmem_req, 0);
    check_eq("rst_retire", retire, 0);
    check_eq("rst_halted", halted, 0);
    check_eq("rst_ovf", ovf, 0);
    check_eq("rst_wb", dbg_wb_data, 0);
    check_eq("rst_pc", dbg_pc, 0);
    check_eq("rst_imem_addr", imem_addr, 0);
    run = 1'b1;
    wait_retires(1, 20, "alu_timeout");
    t0 = last_ret_cyc;
    check_eq("alu_wb0", dbg_wb_data, alu_exp[0]);
    wait_retires(1, 20, "alu_timeout");
    t1 = last_ret_cyc;
    check_eq("alu_wb1", dbg_wb_data, alu_exp[1]);
    wait_retires(1, 20, "alu_timeout");
    t2 = last_ret_cyc;
    check_eq("alu_add_r3", dbg_wb_data, 16'h0002);
    check_eq("alu_gap1", t1 - t0, 5);
    check_eq("alu_gap2", t2 - t1, 5);
    for (int i = 3; i < 9; i++) begin
      wait_retires(1, 20, "alu_timeout");
      check_eq($sformatf("alu_wb%0d", i), dbg_wb_data, alu_exp[i]);
    end
    wait_retires(1, 20, "alu_timeout");
    check_eq("nop_wb_kept", dbg_wb_data, 16'h0001);
    check_eq("nop_pc", dbg_pc, 10);
    check_eq("alu_no_ovf", ovf, 0);
    repeat (10) @(negedge clk);
    check_eq("alu_halted", halted, 1);
    check_eq("alu_halt_pc", dbg_pc, 10);

    // single-step
    clear_imem();
    for (int i = 0; i < 8; i++) imem[i] = enc_i(4'h6, 3'd1, 3'd1, 1);
    do_reset(1'b0);
    base = retire_cnt;
    repeat (20) @(negedge clk);
    check_eq("step_idle_retires", retire_cnt - base, 0);
    check_eq("step_idle_pc", dbg_pc, 0);
    for (int i = 0; i < 3; i++) step_pulse();
    check_eq("step_retires", retire_cnt - base, 3);
    check_eq("step_pc", dbg_pc, 3);
    check_eq("step_wb", dbg_wb_data, 3);
    @(negedge clk);
    step = 1'b1;
    @(negedge clk);
    step = 1'b0;
    @(negedge clk);
    step = 1'b1;
    repeat (25) @(negedge clk);
    check_eq("mid_edge_retires", retire_cnt - base, 4);
    check_eq("mid_edge_pc", dbg_pc, 4);
    step = 1'b0;

    // stores / loads with wait states, then HALT
    clear_imem();
    imem[0] = enc_i(4'h6, 3'd1, 3'd0, 5);
    imem[1] = enc_i(4'h9, 3'd1, 3'd0, 2);
    imem[2] = enc_i(4'h8, 3'd4, 3'd0, 2);
    imem[3] = 16'hF000;
    dmem[2] = 16'h1234;
    dmem_delay = 3;
    len_q.delete(); addr_q.delete(); wd_q.delete(); we_q.delete();
    do_reset(1'b1);
    wait_retires(1, 20, "mem_timeout");
    t0 = last_ret_cyc;
    wait_retires(1, 40, "mem_timeout");
    t1 = last_ret_cyc;
    check_eq("sw_latency", t1 - t0, 9);
    check_eq("sw_stored", dmem[2], 16'h0005);
    wait_retires(1, 40, "mem_timeout");
    t2 = last_ret_cyc;
    check_eq("lw_latency", t2 - t1, 9);
    check_eq("lw_r4", dbg_wb_data, 16'h0005);
    exp_q = '{16'h0002, 16'h0002};
    check_eq("mem_txn_count", len_q.size(), 2);
    for (int i = 0; i < 2 && i < len_q.size(); i++) begin
      check_eq($sformatf("mem_req_len%0d", i), len_q[i], 4);
      check_eq($sformatf("mem_addr%0d", i), addr_q[i], exp_q[i]);
    end
    if (we_q.size() == 2) begin
      check_eq("sw_we", we_q[0], 1);
      check_eq("sw_wdata", wd_q[0], 16'h0005);
      check_eq("lw_we", we_q[1], 0);
    end
    check_eq("mem_stable", stab_err, 0);
    base = retire_cnt;
    repeat (30) @(negedge clk);
    check_eq("halt_flag", halted, 1);
    check_eq("halt_no_retire", retire_cnt - base, 0);
    check_eq("halt_pc", dbg_pc, 3);
    check_eq("halt_no_req", dmem_req, 0);
    dmem_delay = 0;

    // branches
    clear_imem();
    imem[0] = enc_i(4'hA, 3'd0, 3'd0, -1);
    do_reset(1'b1);
    wait_retires(1, 20, "br_timeout");
    check_eq("beq_self_pc", dbg_pc, 0);
    wait_retires(1, 20, "br_timeout");
    check_eq("beq_self_pc2", dbg_pc, 0);
    clear_imem();
    imem[0]   = enc_i(4'hB, 3'd0, 3'd0, 4);
    imem[1]   = enc_i(4'hA, 3'd0, 3'd0, -3);
    imem[255] = enc_i(4'hA, 3'd0, 3'd0, 0);
    do_reset(1'b1);
    wait_retires(1, 20, "br_timeout");
    check_eq("bne_not_taken_pc", dbg_pc, 1);
    wait_retires(1, 20, "br_timeout");
    check_eq("beq_back_pc", dbg_pc, 8'hFF);
    wait_retires(1, 20, "br_timeout");
    check_eq("pc_wrap", dbg_pc, 0);
    clear_imem();
    imem[0] = enc_i(4'h6, 3'd1, 3'd0, 1);
    imem[1] = enc_i(4'hB, 3'd1, 3'd0, 2);
    do_reset(1'b1);
    wait_retires(2, 40, "br_timeout");
    check_eq("bne_taken_pc", dbg_pc, 4);

    // sticky overflow
    clear_imem();
    for (int i = 0; i < 256; i++) imem[i] = enc_i(4'h6, 3'd1, 3'd1, 31);
    imem[0] = enc_i(4'h6, 3'd2, 3'd0, 1);
    do_reset(1'b1);
    wait_retires(1, 20, "ovf_timeout");
    imem[0] = enc_i(4'h6, 3'd1, 3'd1, 31);
    wait_retires(1057, 6000, "ovf_timeout");
    check_eq("ovf_pre_val", dbg_wb_data, 16'h7FFF);
    check_eq("ovf_pre_flag", ovf, 0);
    check_eq("ovf_pre_pc", dbg_pc, 34);
    imem[34] = enc_r(4'h0, 3'd3, 3'd1, 3'd2);
    imem[35] = enc_i(4'h6, 3'd4, 3'd0, 1);
    imem[36] = 16'hF000;
    wait_retires(1, 20, "ovf_timeout");
    check_eq("ovf_add_val", dbg_wb_data, 16'h8000);
    check_eq("ovf_set", ovf, 1);
    wait_retires(1, 20, "ovf_timeout");
    check_eq("ovf_later_val", dbg_wb_data, 16'h0001);
    check_eq("ovf_sticky", ovf, 1);

    // reset during a MEM wait
    clear_imem();
    imem[0] = enc_i(4'h6, 3'd1, 3'd0, 7);
    imem[1] = enc_i(4'h9, 3'd1, 3'd0, 4);
    imem[2] = 16'hF000;
    dmem[4] = 16'hAAAA;
    dmem_delay = 10;
    do_reset(1'b1);
    begin
      int k;
      k = 0;
      while (!dmem_req && k < 40) begin
        @(negedge clk);
        k++;
      end
      check_eq("rstmem_req_seen", dmem_req, 1);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    imem[0] = enc_i(4'h9, 3'd1, 3'd0, 4);
    imem[1] = 16'hF000;
    @(negedge clk);
    dmem_delay = 0;
    check_eq("rstmem_req", dmem_req, 0);
    check_eq("rstmem_we", dmem_we, 0);
    check_eq("rstmem_pc", dbg_pc, 0);
    check_eq("rstmem_halted", halted, 0);
    check_eq("rstmem_retire", retire, 0);
    check_eq("rstmem_wb", dbg_wb_data, 0);
    check_eq("rstmem_ovf", ovf, 0);
    check_eq("rstmem_no_store", dmem[4], 16'hAAAA);
    rst_n = 1'b1;
    wait_retires(1, 30, "rstmem_timeout");
    check_eq("rstmem_regs_cleared", dmem[4], 16'h0000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
